mcdt_rx_demux: RTL and testbench
================================

Name: mcdt_rx_demux

Overview:
Receive-side counterpart of mcdt. Accepts the merged mcdt stream (data, valid, channel id) and demultiplexes it back into three per-channel streams, each with its own FIFO and a valid/ready handshake toward downstream consumers. The mcdt output has no back-pressure, so this block buffers every word it can and flags the words it has to drop. It sits directly on mcdt_data_o / mcdt_val_o / mcdt_id_o.

Parameters:
DEPTH, 32, entries per channel FIFO; power of two, minimum 2.
DW, 32, data width.
MW, $clog2(DEPTH)+1, margin/count width (derived; do not override).

Ports:
clk_i  in  1  clock; all logic on rising edge.
rst_i  in  1  reset, synchronous, active-high.
mcdt_data_i  in  DW  merged stream data.
mcdt_val_i  in  1  merged stream valid; a word is present every cycle this is high.
mcdt_id_i  in  2  target channel, 0..2; 3 is illegal.
chN_data_o  out  DW  channel N head-of-FIFO data (N = 0,1,2).
chN_valid_o  out  1  channel N FIFO not empty.
chN_ready_i  in  1  channel N consumer ready.
chN_margin_o  out  MW  free entries in channel N FIFO (DEPTH - count).
chN_ovf_o  out  1  sticky: channel N dropped at least one word.
id_err_o  out  1  sticky: at least one word arrived with id 3.
clr_i  in  1  one-cycle pulse that clears all sticky flags.

Behaviour:
- Reset (rst_i high at a clock edge):
  - All FIFOs empty; chN_valid_o=0; chN_data_o=0.
  - chN_margin_o=DEPTH; chN_ovf_o=0; id_err_o=0.
  - Reset takes priority over every other input in that cycle. Words in flight are discarded.
- Write:
  - When mcdt_val_i=1 at an edge, the word is pushed into the FIFO selected by mcdt_id_i.
  - No handshake upstream; the word is consumed unconditionally.
- Latency:
  - A word written into an empty FIFO at edge k appears on chN_valid_o/chN_data_o after edge k (one cycle).
  - Show-ahead FIFO: the head is visible without a read request.
- Read:
  - A pop happens at an edge where chN_valid_o=1 and chN_ready_i=1.
  - The next entry (or empty) is shown after that edge.
  - chN_data_o holds its value while valid=1 and ready=0.
  - chN_data_o is don't-care but stable when valid=0 (implementation holds the last value).
- Count/margin:
  - count(next) = count + push - pop.
  - chN_margin_o is registered and updates on the same edge as the count.
- Full boundary:
  - If the FIFO is full and a pop occurs in the same cycle, the incoming word is accepted; the count stays DEPTH.
  - If the FIFO is full with no pop, the word is dropped, contents are unchanged, and chN_ovf_o is set after that edge.
- Empty boundary: a push into an empty FIFO with ready=1 does not bypass; the word is visible the next cycle.
- Illegal id:
  - A word with mcdt_id_i=3 and mcdt_val_i=1 is dropped and id_err_o is set.
  - No FIFO changes.
- Sticky flags:
  - A clr_i pulse clears chN_ovf_o and id_err_o after the edge.
  - If a set event and clr_i occur in the same cycle, the set wins.
- Pointers: rd/wr pointers of $clog2(DEPTH) bits wrap naturally; full/empty are derived from a separate count register.
- Channels are fully independent; pushes to one channel and pops on others can happen in the same cycle.

Optional Feature:
MCDT_RX_CNT_EN
- Defined:
  - Adds outputs chN_cnt_o (16 bits each): the number of words accepted into channel N.
  - Counters saturate at 16'hFFFF, are cleared by rst_i and clr_i, and exclude dropped words.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then 10 words 00C0_0000..00C0_0009 on id 0, one every other cycle, with ch0_ready_i=1 → ch0 emits the same 10 words in order, each one cycle after its input; ch1/ch2 valid stay 0; margins return to 32.
- Same stimulus repeated for id 1 (00C1_000x) and id 2 (00C2_000x) → routed only to the matching channel, in order, with no flags set.
- ch0_ready_i=0, then 33 back-to-back words on id 0 → ch0_margin_o counts down to 0; word 33 is dropped; ch0_ovf_o=1; draining yields exactly words 1..32.
- FIFO full with push and pop in the same cycle → count stays 32; the new word appears last when drained; ch0_ovf_o stays 0.
- Word with id 3 (data DEAD_BEEF) → id_err_o=1; all FIFOs unchanged; a clr_i pulse returns it to 0.
- rst_i asserted with 5 words buffered in ch1 → next cycle ch1_valid_o=0, ch1_margin_o=32, all flags 0.

Source files
------------

// File: rtl/mcdt_rx_demux.sv
// Demultiplexes the merged mcdt stream into three show-ahead channel FIFOs with valid/ready outputs.
// Latency: a word pushed at edge k is visible on its channel after edge k; no bypass of an empty FIFO.
// Backpressure: none upstream; a word for a full channel without a same-cycle pop is dropped and flagged.
// Optional per-channel accepted-word counters are compiled in when MCDT_RX_CNT_EN is defined.
module mcdt_rx_demux #(
    parameter int DEPTH = 32,
    parameter int DW    = 32,
    parameter int MW    = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [DW-1:0] mcdt_data_i,
    input  logic          mcdt_val_i,
    input  logic [1:0]    mcdt_id_i,
    output logic [DW-1:0] ch0_data_o,
    output logic          ch0_valid_o,
    input  logic          ch0_ready_i,
    output logic [MW-1:0] ch0_margin_o,
    output logic          ch0_ovf_o,
    output logic [DW-1:0] ch1_data_o,
    output logic          ch1_valid_o,
    input  logic          ch1_ready_i,
    output logic [MW-1:0] ch1_margin_o,
    output logic          ch1_ovf_o,
    output logic [DW-1:0] ch2_data_o,
    output logic          ch2_valid_o,
    input  logic          ch2_ready_i,
    output logic [MW-1:0] ch2_margin_o,
    output logic          ch2_ovf_o,
`ifdef MCDT_RX_CNT_EN
    output logic [15:0]   ch0_cnt_o,
    output logic [15:0]   ch1_cnt_o,
    output logic [15:0]   ch2_cnt_o,
`endif
    input  logic          clr_i,
    output logic          id_err_o
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [MW-1:0] FULL_CNT = MW'(DEPTH);

    logic [DW-1:0] mem_q    [3][DEPTH];
    logic [PW-1:0] wr_ptr_q [3];
    logic [PW-1:0] wr_ptr_d [3];
    logic [PW-1:0] rd_ptr_q [3];
    logic [PW-1:0] rd_ptr_d [3];
    logic [MW-1:0] count_q  [3];
    logic [MW-1:0] count_d  [3];
    logic [MW-1:0] margin_q [3];
    logic [MW-1:0] margin_d [3];
    logic [DW-1:0] dout_q   [3];
    logic [DW-1:0] dout_d   [3];
    logic          ovf_q    [3];
    logic          ovf_d    [3];
    logic          rdy      [3];
    logic          sel      [3];
    logic          full     [3];
    logic          push     [3];
    logic          pop      [3];
    logic          drop     [3];
    logic          id_err_q;
    logic          id_err_d;

    assign rdy[0] = ch0_ready_i;
    assign rdy[1] = ch1_ready_i;
    assign rdy[2] = ch2_ready_i;

    // Per-channel push/pop decision, pointer/count update and next head-of-FIFO word.
    always_comb begin
        for (int c = 0; c < 3; c++) begin
            sel[c]      = mcdt_val_i && (mcdt_id_i == 2'(c));
            full[c]     = (count_q[c] == FULL_CNT);
            pop[c]      = (count_q[c] != '0) && rdy[c];
            // A full FIFO still accepts when the head leaves in the same cycle.
            push[c]     = sel[c] && (!full[c] || pop[c]);
            drop[c]     = sel[c] && full[c] && !pop[c];
            wr_ptr_d[c] = wr_ptr_q[c] + PW'(push[c]);
            rd_ptr_d[c] = rd_ptr_q[c] + PW'(pop[c]);
            count_d[c]  = count_q[c] + MW'(push[c]) - MW'(pop[c]);
            margin_d[c] = FULL_CNT - count_d[c];
            dout_d[c]   = dout_q[c];
            // The incoming word becomes the head when nothing else will be left in front of it.
            if (push[c] && ((count_q[c] == '0) || (pop[c] && (count_q[c] == MW'(1))))) begin
                dout_d[c] = mcdt_data_i;
            end else if (pop[c] && (count_q[c] > MW'(1))) begin
                dout_d[c] = mem_q[c][rd_ptr_d[c]];
            end
            // Set wins over a simultaneous clear.
            ovf_d[c] = drop[c] | (ovf_q[c] & ~clr_i);
        end
        id_err_d = (mcdt_val_i && (mcdt_id_i == 2'd3)) | (id_err_q & ~clr_i);
    end

    // FIFO storage; contents need no reset because count gates visibility.
    always_ff @(posedge clk_i) begin
        for (int c = 0; c < 3; c++) begin
            if (push[c]) begin
                mem_q[c][wr_ptr_q[c]] <= mcdt_data_i;
            end
        end
    end

    // Control state, registered outputs and sticky flags.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int c = 0; c < 3; c++) begin
                wr_ptr_q[c] <= '0;
                rd_ptr_q[c] <= '0;
                count_q[c]  <= '0;
                margin_q[c] <= FULL_CNT;
                dout_q[c]   <= '0;
                ovf_q[c]    <= 1'b0;
            end
            id_err_q <= 1'b0;
        end else begin
            for (int c = 0; c < 3; c++) begin
                wr_ptr_q[c] <= wr_ptr_d[c];
                rd_ptr_q[c] <= rd_ptr_d[c];
                count_q[c]  <= count_d[c];
                margin_q[c] <= margin_d[c];
                dout_q[c]   <= dout_d[c];
                ovf_q[c]    <= ovf_d[c];
            end
            id_err_q <= id_err_d;
        end
    end

    assign ch0_data_o   = dout_q[0];
    assign ch1_data_o   = dout_q[1];
    assign ch2_data_o   = dout_q[2];
    assign ch0_valid_o  = (count_q[0] != '0);
    assign ch1_valid_o  = (count_q[1] != '0);
    assign ch2_valid_o  = (count_q[2] != '0);
    assign ch0_margin_o = margin_q[0];
    assign ch1_margin_o = margin_q[1];
    assign ch2_margin_o = margin_q[2];
    assign ch0_ovf_o    = ovf_q[0];
    assign ch1_ovf_o    = ovf_q[1];
    assign ch2_ovf_o    = ovf_q[2];
    assign id_err_o     = id_err_q;

`ifdef MCDT_RX_CNT_EN
    logic [15:0] cnt_q [3];
    logic [15:0] cnt_d [3];

    // Accepted-word counters: saturate, skip dropped words, a clear still counts the word of that cycle.
    always_comb begin
        for (int c = 0; c < 3; c++) begin
            if (clr_i) begin
                cnt_d[c] = 16'(push[c]);
            end else if (push[c] && (cnt_q[c] != 16'hFFFF)) begin
                cnt_d[c] = cnt_q[c] + 16'd1;
            end else begin
                cnt_d[c] = cnt_q[c];
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk_i) begin
        for (int c = 0; c < 3; c++) begin
            if (rst_i) begin
                cnt_q[c] <= '0;
            end else begin
                cnt_q[c] <= cnt_d[c];
            end
        end
    end

    assign ch0_cnt_o = cnt_q[0];
    assign ch1_cnt_o = cnt_q[1];
    assign ch2_cnt_o = cnt_q[2];
`endif

endmodule

// File: tb/tb_mcdt_rx_demux.sv
// Bench for mcdt_rx_demux: directed scenarios then random traffic against a queue-based reference model.
// Every cycle the model predicts valid/data/margin/flags per channel and each is compared after the edge.
// Ready is driven per channel to exercise full, empty and simultaneous push/pop boundaries.
module tb_mcdt_rx_demux;

    localparam int DEPTH = 32;
    localparam int DW    = 32;
    localparam int MW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_i;
    logic [DW-1:0] mcdt_data_i;
    logic          mcdt_val_i;
    logic [1:0]    mcdt_id_i;
    logic          clr_i;
    logic          rdy     [3];
    logic [DW-1:0] data_o  [3];
    logic          valid_o [3];
    logic [MW-1:0] margin_o[3];
    logic          ovf_o   [3];
    logic          id_err_o;
`ifdef MCDT_RX_CNT_EN
    logic [15:0]   cnt_o   [3];
`endif

    always #5 clk = ~clk;

    mcdt_rx_demux #(.DEPTH(DEPTH), .DW(DW)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .mcdt_data_i(mcdt_data_i), .mcdt_val_i(mcdt_val_i), .mcdt_id_i(mcdt_id_i),
        .ch0_data_o(data_o[0]), .ch0_valid_o(valid_o[0]), .ch0_ready_i(rdy[0]),
        .ch0_margin_o(margin_o[0]), .ch0_ovf_o(ovf_o[0]),
        .ch1_data_o(data_o[1]), .ch1_valid_o(valid_o[1]), .ch1_ready_i(rdy[1]),
        .ch1_margin_o(margin_o[1]), .ch1_ovf_o(ovf_o[1]),
        .ch2_data_o(data_o[2]), .ch2_valid_o(valid_o[2]), .ch2_ready_i(rdy[2]),
        .ch2_margin_o(margin_o[2]), .ch2_ovf_o(ovf_o[2]),
`ifdef MCDT_RX_CNT_EN
        .ch0_cnt_o(cnt_o[0]), .ch1_cnt_o(cnt_o[1]), .ch2_cnt_o(cnt_o[2]),
`endif
        .clr_i(clr_i), .id_err_o(id_err_o)
    );

    // Reference model state
    logic [31:0] mq [3][$];
    bit          m_ovf [3];
    bit          m_id_err;
    int          m_cnt [3];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply current inputs to the model, clock once, then compare every channel.
    task automatic step();
        bit pops [3];
        if (rst_i) begin
            for (int c = 0; c < 3; c++) begin
                mq[c].delete();
                m_ovf[c] = 0;
                m_cnt[c] = 0;
            end
            m_id_err = 0;
        end else begin
            for (int c = 0; c < 3; c++) pops[c] = (mq[c].size() > 0) && rdy[c];
            for (int c = 0; c < 3; c++) begin
                bit hit;
                bit acc;
                hit = mcdt_val_i && (int'(mcdt_id_i) == c);
                if (pops[c]) void'(mq[c].pop_front());
                acc = hit && (mq[c].size() < DEPTH);
                if (acc) mq[c].push_back(mcdt_data_i);
                if (clr_i) m_ovf[c] = 0;
                if (hit && !acc) m_ovf[c] = 1;
                if (clr_i) m_cnt[c] = 0;
                if (acc && m_cnt[c] < 65535) m_cnt[c]++;
            end
            if (clr_i) m_id_err = 0;
            if (mcdt_val_i && mcdt_id_i == 2'd3) m_id_err = 1;
        end
        @(posedge clk);
        #1;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("valid%0d", c), 32'(valid_o[c]), 32'(mq[c].size() > 0));
            if (mq[c].size() > 0) chk($sformatf("data%0d", c), data_o[c], mq[c][0]);
            chk($sformatf("margin%0d", c), 32'(margin_o[c]), 32'(DEPTH - mq[c].size()));
            chk($sformatf("ovf%0d", c), 32'(ovf_o[c]), 32'(m_ovf[c]));
`ifdef MCDT_RX_CNT_EN
            chk($sformatf("cnt%0d", c), 32'(cnt_o[c]), 32'(m_cnt[c]));
`endif
        end
        chk("id_err", 32'(id_err_o), 32'(m_id_err));
    endtask

    task automatic idle_inputs();
        mcdt_val_i  = 1'b0;
        mcdt_id_i   = 2'd0;
        mcdt_data_i = '0;
        clr_i       = 1'b0;
        rst_i       = 1'b0;
    endtask

    initial begin
        int pct;
        idle_inputs();
        for (int c = 0; c < 3; c++) rdy[c] = 1'b1;

        // Reset state
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        for (int c = 0; c < 3; c++) chk($sformatf("rst_data%0d", c), data_o[c], 32'h0);
        step();

        // Ten words per channel, one every other cycle, consumer always ready
        for (int id = 0; id < 3; id++) begin
            for (int i = 0; i < 10; i++) begin
                mcdt_val_i  = 1'b1;
                mcdt_id_i   = 2'(id);
                mcdt_data_i = 32'h00C0_0000 + (id << 16) + i;
                step();
                chk("route_data", data_o[id], 32'h00C0_0000 + (id << 16) + i);
                mcdt_val_i = 1'b0;
                step();
            end
            chk("route_margin", 32'(margin_o[id]), DEPTH);
        end

        // Overflow: 33 back-to-back words into a stalled ch0
        rdy[0] = 1'b0;
        for (int i = 1; i <= 33; i++) begin
            mcdt_val_i  = 1'b1;
            mcdt_id_i   = 2'd0;
            mcdt_data_i = 32'h0A00_0000 + i;
            step();
            if (i == 32) chk("full_margin", 32'(margin_o[0]), 0);
        end
        chk("ovf_set", 32'(ovf_o[0]), 1);
        mcdt_val_i = 1'b0;
        rdy[0] = 1'b1;
        for (int i = 0; i < 33; i++) step();
        clr_i = 1'b1;
        step();
        clr_i = 1'b0;
        chk("ovf_clr", 32'(ovf_o[0]), 0);

        // Full FIFO with push and pop in the same cycle
        rdy[0] = 1'b0;
        for (int i = 0; i < 32; i++) begin
            mcdt_val_i  = 1'b1;
            mcdt_data_i = 32'h0B00_0000 + i;
            step();
        end
        rdy[0] = 1'b1;
        mcdt_data_i = 32'h0B00_00FF;
        step();
        chk("fullpp_margin", 32'(margin_o[0]), 0);
        chk("fullpp_ovf", 32'(ovf_o[0]), 0);
        mcdt_val_i = 1'b0;
        for (int i = 0; i < 31; i++) step();
        chk("fullpp_last", data_o[0], 32'h0B00_00FF);
        step();

        // Illegal id
        mcdt_val_i  = 1'b1;
        mcdt_id_i   = 2'd3;
        mcdt_data_i = 32'hDEAD_BEEF;
        step();
        chk("id_err_set", 32'(id_err_o), 1);
        mcdt_val_i = 1'b0;
        clr_i = 1'b1;
        step();
        clr_i = 1'b0;
        chk("id_err_clr", 32'(id_err_o), 0);

        // Reset with words buffered in ch1
        rdy[1] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            mcdt_val_i  = 1'b1;
            mcdt_id_i   = 2'd1;
            mcdt_data_i = 32'h0C00_0000 + i;
            step();
        end
        mcdt_val_i = 1'b0;
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        chk("rst_valid1", 32'(valid_o[1]), 0);
        chk("rst_margin1", 32'(margin_o[1]), DEPTH);
        rdy[1] = 1'b1;
        step();

        // Random traffic with alternating consumer pressure
        pct = 90;
        for (int n = 0; n < 3000; n++) begin
            if (n % 300 == 0) pct = (pct == 90) ? 15 : 90;
            mcdt_val_i  = ($urandom_range(0, 3) != 0);
            mcdt_id_i   = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            mcdt_data_i = $urandom;
            for (int c = 0; c < 3; c++) rdy[c] = ($urandom_range(0, 99) < pct);
            clr_i = ($urandom_range(0, 49) == 0);
            rst_i = ($urandom_range(0, 999) == 0);
            step();
        end
        idle_inputs();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
